// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path.
//   digit_idx_t : 2-bit scan slot index (0 = rightmost digit)
//   SEG_OFF     : active-high pattern with every segment dark
//   HEX_SEG     : nibble to active-high {g,f,e,d,c,b,a} pattern table
package seg_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-digit decoder.
//   nibble  : 4-bit value to display
//   pattern : active-high segment pattern {g,f,e,d,c,b,a}
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/i2c_seg_display.sv
// Latches the I2C master's data and state bytes on an update strobe and shows
// them as four hex digits on a time-multiplexed 7-segment display.
//   clk, reset : system clock, asynchronous active-low reset
//   out, state : data and state bytes from the master driver
//   ready      : controller ready; when low, the rightmost decimal point blinks
//   update     : single-cycle capture strobe for out/state
//   seg        : segments {g,f,e,d,c,b,a}
//   dp         : decimal point
//   dig        : digit enables, dig[0] is the rightmost digit
// seg/dp/dig are active-low when COMMON_ANODE = 1, active-high otherwise.
module i2c_seg_display
    import seg_pkg::*;
#(
    parameter int unsigned DIGIT_DIV    = 50000,
    parameter int unsigned BLANK_CYC    = 64,
    parameter int unsigned BLINK_DIV    = 12500000,
    parameter bit          COMMON_ANODE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] out,
    input  logic [7:0] state,
    input  logic       ready,
    input  logic       update,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] dig
);

    localparam int unsigned DIV_W   = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIGIT_DIV - 1);
    localparam logic [DIV_W-1:0]   BLANK_END  = DIV_W'(BLANK_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // XOR masks turn active-high internal values into pin polarity.
    localparam logic [6:0] SEG_POL = {7{COMMON_ANODE}};
    localparam logic [3:0] DIG_POL = {4{COMMON_ANODE}};

    logic [7:0]         data_q;
    logic [7:0]         state_q;
    logic [DIV_W-1:0]   div_cnt;
    digit_idx_t         idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink;

    logic [3:0] nibble_p0;
    logic [6:0] seg_p0;
    logic       dp_p0;
    logic [3:0] dig_p0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= 8'h00;
            state_q <= 8'h00;
        end else if (update) begin
            data_q  <= out;
            state_q <= state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Stage p0: select the nibble for the current slot and decode it.
    always_comb begin
        nibble_p0 = data_q[3:0];
        dp_p0     = 1'b0;
        unique case (idx)
            2'd0: begin
                nibble_p0 = data_q[3:0];
                dp_p0     = ~ready & blink;
            end
            2'd1: nibble_p0 = data_q[7:4];
            2'd2: begin
                nibble_p0 = state_q[3:0];
                dp_p0     = 1'b1;
            end
            2'd3: nibble_p0 = state_q[7:4];
            default: nibble_p0 = data_q[3:0];
        endcase
    end

    seg7_decode u_decode (
        .nibble  (nibble_p0),
        .pattern (seg_p0)
    );

    // The segment lines settle during the blank window, so only dig is gated.
    assign dig_p0 = (div_cnt >= BLANK_END) ? (4'b0001 << idx) : 4'b0000;

    // Stage p1: registered outputs in pin polarity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_OFF ^ SEG_POL;
            dp  <= COMMON_ANODE;
            dig <= DIG_POL;
        end else begin
            seg <= seg_p0 ^ SEG_POL;
            dp  <= dp_p0 ^ COMMON_ANODE;
            dig <= dig_p0 ^ DIG_POL;
        end
    end

endmodule

// File: tb/tb_i2c_seg_display.sv
// Directed bench for i2c_seg_display: one common-anode and one common-cathode
// instance share clock, reset and inputs.
module tb_i2c_seg_display;

    localparam int DD = 8;
    localparam int BC = 2;
    localparam int BD = 20;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] out_v  = 8'h00;
    logic [7:0] state_v = 8'h00;
    logic       ready  = 1'b1;
    logic       update = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] dig_a, dig_b;

    int tests = 0;
    int fails = 0;
    int cyc;

    always #5 clk = ~clk;

    i2c_seg_display #(
        .DIGIT_DIV(DD), .BLANK_CYC(BC), .BLINK_DIV(BD), .COMMON_ANODE(1'b1)
    ) u_dut_ca (
        .clk(clk), .reset(reset), .out(out_v), .state(state_v),
        .ready(ready), .update(update),
        .seg(seg_a), .dp(dp_a), .dig(dig_a)
    );

    i2c_seg_display #(
        .DIGIT_DIV(DD), .BLANK_CYC(BC), .BLINK_DIV(BD), .COMMON_ANODE(1'b0)
    ) u_dut_cc (
        .clk(clk), .reset(reset), .out(out_v), .state(state_v),
        .ready(ready), .update(update),
        .seg(seg_b), .dp(dp_b), .dig(dig_b)
    );

    // Clock edges since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] cur_dig(input bit cc);
        return cc ? dig_b : dig_a;
    endfunction

    // Waits for the start of a fresh slot in which the chosen instance shows want.
    task automatic wait_dig(input bit cc, input logic [3:0] want, input string tag);
        int n = 0;
        while (cur_dig(cc) == want && n < 200) begin tick(); n++; end
        while (cur_dig(cc) != want && n < 200) begin tick(); n++; end
        check_eq({tag, "_reach"}, {28'd0, cur_dig(cc)}, {28'd0, want});
    endtask

    task automatic check_slot(input bit cc, input logic [3:0] want_dig,
                              input logic [6:0] want_seg, input logic want_dp,
                              input string tag);
        wait_dig(cc, want_dig, tag);
        check_eq({tag, "_seg"}, {25'd0, cc ? seg_b : seg_a}, {25'd0, want_seg});
        check_eq({tag, "_dp"},  {31'd0, cc ? dp_b : dp_a},   {31'd0, want_dp});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ca_seg"}, {25'd0, seg_a}, 32'h7F);
        check_eq({tag, "_ca_dp"},  {31'd0, dp_a},  32'h1);
        check_eq({tag, "_ca_dig"}, {28'd0, dig_a}, 32'hF);
        check_eq({tag, "_cc_seg"}, {25'd0, seg_b}, 32'h0);
        check_eq({tag, "_cc_dp"},  {31'd0, dp_b},  32'h0);
        check_eq({tag, "_cc_dig"}, {28'd0, dig_b}, 32'h0);
    endtask

    // After release: blank for BC edges, then slot 0 lights showing zero.
    task automatic check_restart(input string tag);
        for (int k = 1; k <= BC; k++) begin
            tick();
            check_eq({tag, "_blank_dig"}, {28'd0, dig_a}, 32'hF);
        end
        tick();
        check_eq({tag, "_first_dig"}, {28'd0, dig_a}, 32'hE);
        check_eq({tag, "_first_seg"}, {25'd0, seg_a}, 32'h40);
        check_eq({tag, "_first_cc_dig"}, {28'd0, dig_b}, 32'h1);
        check_eq({tag, "_first_cc_seg"}, {25'd0, seg_b}, 32'h3F);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit blink_exp;
        bit saw_on, saw_off;

        // Reset state
        #2 reset = 1'b0;
        #1 check_reset_outputs("por");
        tick();
        tick();
        check_reset_outputs("por_hold");
        reset = 1'b1;
        check_restart("por");

        // Basic scan, both polarities
        out_v   = 8'hA5;
        state_v = 8'h3C;
        update  = 1'b1;
        tick();
        update  = 1'b0;
        check_slot(1'b0, 4'hE, 7'h12, 1'b1, "scan_d0");
        check_slot(1'b0, 4'hD, 7'h08, 1'b1, "scan_d1");
        check_slot(1'b0, 4'hB, 7'h46, 1'b0, "scan_d2");
        check_slot(1'b0, 4'h7, 7'h30, 1'b1, "scan_d3");
        check_slot(1'b1, 4'h1, 7'h6D, 1'b0, "cc_d0");
        check_slot(1'b1, 4'h2, 7'h77, 1'b0, "cc_d1");
        check_slot(1'b1, 4'h4, 7'h39, 1'b1, "cc_d2");
        check_slot(1'b1, 4'h8, 7'h4F, 1'b0, "cc_d3");

        // Input change without update stays invisible
        out_v = 8'h42;
        for (int f = 0; f < 2; f++) begin
            check_slot(1'b0, 4'hE, 7'h12, 1'b1, "gate_d0");
            check_slot(1'b0, 4'hD, 7'h08, 1'b1, "gate_d1");
            check_slot(1'b0, 4'hB, 7'h46, 1'b0, "gate_d2");
            check_slot(1'b0, 4'h7, 7'h30, 1'b1, "gate_d3");
        end
        update = 1'b1;
        tick();
        update = 1'b0;
        check_slot(1'b0, 4'hE, 7'h24, 1'b1, "upd_d0");
        check_slot(1'b0, 4'hD, 7'h19, 1'b1, "upd_d1");

        // Update held high: display follows input two edges later
        update = 1'b1;
        out_v  = 8'h07;
        wait_dig(1'b0, 4'hE, "held");
        tick();
        tick();
        check_eq("held_07", {25'd0, seg_a}, 32'h78);
        out_v = 8'h08;
        tick();
        tick();
        check_eq("held_08_dig", {28'd0, dig_a}, 32'hE);
        check_eq("held_08", {25'd0, seg_a}, 32'h00);
        update = 1'b0;

        // Not-ready blink on the rightmost decimal point
        ready   = 1'b0;
        saw_on  = 1'b0;
        saw_off = 1'b0;
        for (int i = 0; i < 320; i++) begin
            tick();
            if (dig_a == 4'hE) begin
                blink_exp = (((cyc - 1) / BD) % 2) == 1;
                check_eq("blink_dp", {31'd0, dp_a}, {31'd0, ~blink_exp});
                if (dp_a == 1'b0) saw_on = 1'b1;
                else              saw_off = 1'b1;
            end
            if (dig_a == 4'hB) check_eq("blink_sep_dp", {31'd0, dp_a}, 32'h0);
        end
        check_eq("blink_both_phases", {30'd0, saw_on, saw_off}, 32'h3);
        ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (dig_a == 4'hE) check_eq("ready_dp", {31'd0, dp_a}, 32'h1);
            if (dig_a == 4'hB) check_eq("ready_sep_dp", {31'd0, dp_a}, 32'h0);
        end

        // Asynchronous reset in the middle of the separator slot
        wait_dig(1'b0, 4'hB, "mid");
        #3 reset = 1'b0;
        #1 check_reset_outputs("mid_rst");
        tick();
        reset = 1'b1;
        check_restart("mid_rel");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
